// File: rtl/tff_toggle_rx_if.sv
// Toggle-link receive bus: sender level and consumer ack in; event strobe,
// pending/overrun flags, mirrored TFF level and event count out.
//   tgl_in   toggle level from the sender (each change = one event)
//   ack      consumer acknowledge, clears pend
//   pulse    one-cycle strobe per detected event
//   pend     event waiting for ack
//   ovr      sticky overrun flag
//   q/q_bar  mirror of the sender level and its complement
//   evt_cnt  event count modulo 2^CNT_W
// Modports: master = sender/consumer side, slave = receiver (tff_toggle_rx).
interface tff_toggle_rx_if #(
    parameter int unsigned CNT_W = 8
);
    logic             tgl_in;
    logic             ack;
    logic             pulse;
    logic             pend;
    logic             ovr;
    logic             q;
    logic             q_bar;
    logic [CNT_W-1:0] evt_cnt;

    modport master (
        output tgl_in,
        output ack,
        input  pulse,
        input  pend,
        input  ovr,
        input  q,
        input  q_bar,
        input  evt_cnt
    );

    modport slave (
        input  tgl_in,
        input  ack,
        output pulse,
        output pend,
        output ovr,
        output q,
        output q_bar,
        output evt_cnt
    );
endinterface

// File: rtl/tff_toggle_rx.sv
// Receive end of a T-flip-flop toggle link. Each change of the sender level
// becomes a one-cycle pulse; pend is held until the consumer acks, events that
// arrive while pend is set raise the sticky ovr flag. The sender's q/q_bar are
// mirrored and events are counted modulo 2^CNT_W.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   tff_toggle_rx_if.slave (tgl_in, ack in; pulse, pend, ovr, q,
//         q_bar, evt_cnt out)
// Configuration macro: TFF_RX_SYNC_EN -- when defined, tgl_in passes through a
//   SYNC_STAGES-deep synchronizer and the arm phase waits for it to fill.
module tff_toggle_rx #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    tff_toggle_rx_if.slave bus
);

`ifdef TFF_RX_SYNC_EN
    localparam int unsigned ARM_LEN = SYNC_STAGES;
`else
    localparam int unsigned ARM_LEN = 0;
`endif
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_r;
    logic             tgl_s;
    logic             prev_r;
    logic             pulse_r;
    logic             pend_r;
    logic             ovr_r;
    logic             q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ARM_W-1:0] arm_cnt_r;
    logic             evt_c;
    logic             arm_done_c;

`ifdef TFF_RX_SYNC_EN
    // Synchronizer for an asynchronous sender.
    logic [SYNC_STAGES-1:0] sync_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.tgl_in};
        end
    end

    assign tgl_s = sync_r[SYNC_STAGES-1];
`else
    assign tgl_s = bus.tgl_in;
`endif

    // A level difference against the previous sample is one event.
    assign evt_c      = (tgl_s != prev_r);
    // Arm completes once the synchronizer holds a valid sample (immediately without one).
    assign arm_done_c = (arm_cnt_r == ARM_W'(ARM_LEN));

    // Receive FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ARM;
            prev_r    <= 1'b0;
            pulse_r   <= 1'b0;
            pend_r    <= 1'b0;
            ovr_r     <= 1'b0;
            q_r       <= 1'b0;
            cnt_r     <= '0;
            arm_cnt_r <= '0;
        end else begin
            pulse_r <= 1'b0;
            prev_r  <= tgl_s;
            case (state_r)
                ARM: begin
                    // Adopt the current level without treating it as an event.
                    if (arm_done_c) begin
                        q_r     <= tgl_s;
                        state_r <= IDLE;
                    end else begin
                        arm_cnt_r <= arm_cnt_r + ARM_W'(1);
                    end
                end
                IDLE: begin
                    if (evt_c) begin
                        pulse_r <= 1'b1;
                        q_r     <= ~q_r;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        pend_r  <= 1'b1;
                        state_r <= PEND;
                    end
                end
                PEND: begin
                    if (evt_c) begin
                        // New event replaces the acked one, or overruns an unacked one.
                        pulse_r <= 1'b1;
                        q_r     <= ~q_r;
                        cnt_r   <= cnt_r + CNT_W'(1);
                        if (!bus.ack) begin
                            ovr_r <= 1'b1;
                        end
                    end else if (bus.ack) begin
                        pend_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= ARM;
                end
            endcase
        end
    end

    assign bus.pulse   = pulse_r;
    assign bus.pend    = pend_r;
    assign bus.ovr     = ovr_r;
    assign bus.q       = q_r;
    assign bus.q_bar   = ~q_r;
    assign bus.evt_cnt = cnt_r;

endmodule
